mmio_responder: RTL and testbench

- Memory-mapped I/O responder on the processor's data-memory port, the responder end of the load/store interface the CPU initiates.
- Decodes a small register window above RAM and holds three resources:
  - a button-event FIFO fed by the input debouncer;
  - a programmable game-tick timer with a sticky flag;
  - a score register driving the display.
- Its read data is muxed with RAM q_dmem by the wrapper, using io_hit.

---
 rtl/mmio_pkg.sv | 21 ++
 rtl/io_sync_fifo.sv | 67 ++++++
 rtl/mmio_responder.sv | 154 +++++++++++++++
 tb/tb_mmio_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// ============================================================================
// Module   : mmio_pkg
// Purpose  : Register offsets and field positions of the MMIO register window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmio_pkg;

    localparam logic [11:0] OFF_BTN_DATA    = 12'd0;
    localparam logic [11:0] OFF_BTN_STATUS  = 12'd1;
    localparam logic [11:0] OFF_TICK_PERIOD = 12'd2;
    localparam logic [11:0] OFF_TICK_FLAG   = 12'd3;
    localparam logic [11:0] OFF_SCORE       = 12'd4;

    localparam int VALID_BIT = 8;
    localparam int OVF_BIT   = 8;

endpackage

`default_nettype wire

// File: rtl/io_sync_fifo.sv
// ============================================================================
// Module   : io_sync_fifo
// Purpose  : Synchronous circular FIFO with extra-MSB pointers; a push is
//            accepted while full when a pop happens on the same edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    r_wr_q;
    logic [PW-1:0]    r_rd_q;
    logic [PW-1:0]    w_wr_d;
    logic [PW-1:0]    w_rd_d;
    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_wr_q == r_rd_q);
    assign o_full  = (r_wr_q[AW] != r_rd_q[AW]) && (r_wr_q[AW-1:0] == r_rd_q[AW-1:0]);
    assign o_count = r_wr_q - r_rd_q;
    assign o_dout  = r_mem_q[r_rd_q[AW-1:0]];

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_comb begin
        w_wr_d = r_wr_q + PW'(w_do_push);
        w_rd_d = r_rd_q + PW'(w_do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_q <= '0;
            r_rd_q <= '0;
        end else begin
            r_wr_q <= w_wr_d;
            r_rd_q <= w_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem_q[r_wr_q[AW-1:0]] <= i_din;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mmio_responder.sv
// ============================================================================
// Module   : mmio_responder
// Purpose  : Data-memory-port responder for the button FIFO, game-tick timer
//            and score register window; read data has one cycle of latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR  = 12'hF00,
    parameter int          FIFO_DEPTH = 8,
    parameter int          CODE_W     = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [11:0]       address_dmem,
    input  logic [31:0]       data,
    input  logic              wren,
    input  logic              ren,
    output logic [31:0]       q_io,
    output logic              io_hit,
    input  logic              btn_event,
    input  logic [CODE_W-1:0] btn_code,
    output logic [31:0]       score_out,
    output logic              tick_irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [11:0]       w_off;
    logic              w_rd_hit;
    logic              w_wr_hit;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CODE_W-1:0] w_head;
    logic [CW-1:0]     w_count;
    logic [31:0]       w_rd_data;
    logic              w_period_wr;
    logic              w_wrap;

    logic [31:0] r_q_io_q,   w_q_io_d;
    logic        r_io_hit_q, w_io_hit_d;
    logic        r_ovf_q,    w_ovf_d;
    logic [31:0] r_period_q, w_period_d;
    logic [31:0] r_cnt_q,    w_cnt_d;
    logic        r_flag_q,   w_flag_d;
    logic [31:0] r_score_q,  w_score_d;

    // Addresses below the base wrap to large offsets and fall outside the window.
    assign w_off    = address_dmem - BASE_ADDR;
    assign w_rd_hit = ren  && (w_off <= OFF_SCORE);
    assign w_wr_hit = wren && (w_off <= OFF_SCORE);
    assign w_pop    = w_rd_hit && (w_off == OFF_BTN_DATA) && !w_empty;

    io_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CODE_W)
    ) u_btn_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_push  (btn_event),
        .i_pop   (w_pop),
        .i_din   (btn_code),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_rd_data = '0;
        case (w_off)
            OFF_BTN_DATA: begin
                if (!w_empty) begin
                    w_rd_data[VALID_BIT]    = 1'b1;
                    w_rd_data[CODE_W-1:0]   = w_head;
                end
            end
            OFF_BTN_STATUS: begin
                w_rd_data          = 32'(w_count) & 32'h1F;
                w_rd_data[OVF_BIT] = r_ovf_q;
            end
            OFF_TICK_PERIOD: w_rd_data = r_period_q;
            OFF_TICK_FLAG:   w_rd_data = {31'd0, r_flag_q};
            OFF_SCORE:       w_rd_data = r_score_q;
            default:         w_rd_data = '0;
        endcase
    end

    assign w_period_wr = w_wr_hit && (w_off == OFF_TICK_PERIOD);
    assign w_wrap      = (r_period_q != 32'd0) && (r_cnt_q == r_period_q - 32'd1);

    always_comb begin
        w_q_io_d   = w_rd_hit ? w_rd_data : 32'd0;
        w_io_hit_d = w_rd_hit;

        w_ovf_d = r_ovf_q;
        if (w_wr_hit && (w_off == OFF_BTN_STATUS)) begin
            w_ovf_d = 1'b0;
        end
        if (btn_event && w_full && !w_pop) begin
            w_ovf_d = 1'b1;
        end

        w_period_d = w_period_wr ? data : r_period_q;
        w_score_d  = (w_wr_hit && (w_off == OFF_SCORE)) ? data : r_score_q;

        // A period write restarts the count and suppresses a coincident wrap.
        if (w_period_wr || (r_period_q == 32'd0) || w_wrap) begin
            w_cnt_d = 32'd0;
        end else begin
            w_cnt_d = r_cnt_q + 32'd1;
        end

        w_flag_d = r_flag_q;
        if (w_rd_hit && (w_off == OFF_TICK_FLAG)) begin
            w_flag_d = 1'b0;
        end
        if (w_wrap && !w_period_wr) begin
            w_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q_io_q   <= '0;
            r_io_hit_q <= 1'b0;
            r_ovf_q    <= 1'b0;
            r_period_q <= '0;
            r_cnt_q    <= '0;
            r_flag_q   <= 1'b0;
            r_score_q  <= '0;
        end else begin
            r_q_io_q   <= w_q_io_d;
            r_io_hit_q <= w_io_hit_d;
            r_ovf_q    <= w_ovf_d;
            r_period_q <= w_period_d;
            r_cnt_q    <= w_cnt_d;
            r_flag_q   <= w_flag_d;
            r_score_q  <= w_score_d;
        end
    end

    assign q_io      = r_q_io_q;
    assign io_hit    = r_io_hit_q;
    assign score_out = r_score_q;
    assign tick_irq  = r_flag_q;

endmodule

`default_nettype wire

// File: tb/tb_mmio_responder.sv
// ============================================================================
// Module   : tb_mmio_responder
// Purpose  : Directed and randomized checks of mmio_responder against a
//            queue/absolute-time reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_responder;

    localparam logic [11:0] BASE  = 12'hF00;
    localparam int          DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] address_dmem = '0;
    logic [31:0] data = '0;
    logic        wren = 1'b0;
    logic        ren = 1'b0;
    logic [31:0] q_io;
    logic        io_hit;
    logic        btn_event = 1'b0;
    logic [3:0]  btn_code = '0;
    logic [31:0] score_out;
    logic        tick_irq;

    mmio_responder #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH),
        .CODE_W     (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .ren          (ren),
        .q_io         (q_io),
        .io_hit       (io_hit),
        .btn_event    (btn_event),
        .btn_code     (btn_code),
        .score_out    (score_out),
        .tick_irq     (tick_irq)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: button queue, absolute edge of the next tick.
    int unsigned m_q[$];
    bit          m_ovf;
    logic [31:0] m_period;
    logic [31:0] m_score;
    bit          m_flag;
    longint      m_cyc  = 0;
    longint      m_next = 0;
    logic [31:0] e_q;
    bit          e_hit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit w, input logic [11:0] a, input logic [31:0] d,
                         input bit be, input logic [3:0] bc, input bit rs);
        int  off;
        bit  rh, wh, pop, ovf_set;
        int  pre;
        m_cyc++;
        e_q   = 32'd0;
        e_hit = 1'b0;
        if (rs) begin
            m_q.delete();
            m_ovf = 0; m_period = 0; m_score = 0; m_flag = 0;
            return;
        end
        off = int'(a) - int'(BASE);
        rh  = r && off >= 0 && off <= 4;
        wh  = w && off >= 0 && off <= 4;
        pre = m_q.size();
        if (rh) begin
            e_hit = 1'b1;
            case (off)
                0: e_q = (pre > 0) ? (32'h100 | 32'(m_q[0])) : 32'h0;
                1: e_q = 32'(pre) | (m_ovf ? 32'h100 : 32'h0);
                2: e_q = m_period;
                3: e_q = 32'(m_flag);
                default: e_q = m_score;
            endcase
        end
        pop = rh && off == 0 && pre > 0;
        if (pop) void'(m_q.pop_front());
        ovf_set = 0;
        if (be) begin
            if (pre < DEPTH || pop) m_q.push_back(int'(bc));
            else ovf_set = 1;
        end
        if (wh && off == 1) m_ovf = 0;
        if (ovf_set) m_ovf = 1;
        if (rh && off == 3) m_flag = 0;
        if (wh && off == 2) begin
            m_period = d;
            m_next   = m_cyc + longint'(d);
        end else if (m_period != 0 && m_cyc == m_next) begin
            m_flag = 1;
            m_next = m_next + longint'(m_period);
        end
        if (wh && off == 4) m_score = d;
    endtask

    task automatic step(input bit r, input bit w, input logic [11:0] a, input logic [31:0] d,
                        input bit be, input logic [3:0] bc, input bit rs);
        @(negedge clock);
        ren = r; wren = w; address_dmem = a; data = d;
        btn_event = be; btn_code = bc; reset = rs;
        @(posedge clock);
        model(r, w, a, d, be, bc, rs);
        #1;
        chk("q_io", q_io, e_q);
        chk("io_hit", 32'(io_hit), 32'(e_hit));
        chk("score_out", score_out, m_score);
        chk("tick_irq", 32'(tick_irq), 32'(m_flag));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 12'h0, 32'h0, 0, 4'h0, 0);
    endtask

    task automatic rd(input int off);
        step(1, 0, BASE + 12'(off), 32'h0, 0, 4'h0, 0);
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        step(0, 1, BASE + 12'(off), d, 0, 4'h0, 0);
    endtask

    task automatic push(input logic [3:0] c);
        step(0, 0, 12'h0, 32'h0, 1, c, 0);
    endtask

    initial begin
        step(0, 0, 12'h0, 32'h0, 0, 4'h0, 1);
        step(0, 0, 12'h0, 32'h0, 0, 4'h0, 1);
        chk("reset_score", score_out, 32'h0);

        rd(1);
        chk("status_after_reset_hit", 32'(io_hit), 32'h1);
        chk("status_after_reset_q", q_io, 32'h0);
        wr(4, 32'd1234);
        idle(1);
        chk("score_out_1234", score_out, 32'd1234);
        rd(4);
        chk("score_read_1234", q_io, 32'd1234);
        wr(4, 32'd1234);
        step(1, 0, BASE - 12'd1, 32'h0, 0, 4'h0, 0);
        chk("below_window_hit", 32'(io_hit), 32'h0);
        step(1, 0, BASE + 12'd5, 32'h0, 0, 4'h0, 0);
        chk("above_window_q", q_io, 32'h0);

        push(4'd3); push(4'd7); push(4'd12);
        rd(0); chk("pop_3", q_io, 32'h103);
        rd(0); chk("pop_7", q_io, 32'h107);
        rd(0); chk("pop_12", q_io, 32'h10C);
        rd(0); chk("pop_empty", q_io, 32'h000);
        rd(1); chk("occ_after_drain", q_io, 32'h0);

        for (int i = 0; i < 9; i++) push(4'(i));
        rd(1); chk("status_overflow", q_io, 32'h108);
        wr(1, 32'h0);
        rd(1); chk("status_ovf_cleared", q_io, 32'h008);
        step(1, 0, BASE, 32'h0, 1, 4'd5, 0);
        chk("pushpop_full_head", q_io, 32'h100);
        rd(1); chk("pushpop_full_status", q_io, 32'h008);
        for (int i = 0; i < 8; i++) rd(0);

        wr(2, 32'd5);
        idle(4); chk("tick_not_yet", 32'(tick_irq), 32'h0);
        idle(1); chk("tick_at_5", 32'(tick_irq), 32'h1);
        rd(3);   chk("flag_read_1", q_io, 32'h1);
        chk("flag_cleared", 32'(tick_irq), 32'h0);
        idle(3); chk("tick2_not_yet", 32'(tick_irq), 32'h0);
        idle(1); chk("tick2_at_10", 32'(tick_irq), 32'h1);
        rd(3);
        idle(3);
        rd(3);
        chk("clear_on_wrap_q", q_io, 32'h0);
        chk("clear_on_wrap_irq", 32'(tick_irq), 32'h1);

        idle(2);
        wr(2, 32'd0);
        rd(3);
        idle(100);
        chk("period0_no_tick", 32'(tick_irq), 32'h0);

        for (int i = 0; i < 400; i++) begin
            int op, sel;
            logic [11:0] a;
            logic [31:0] d;
            op  = int'($urandom_range(0, 2));
            sel = int'($urandom_range(0, 9));
            if (sel < 8)       a = BASE + 12'($urandom_range(0, 4));
            else if (sel == 8) a = BASE + 12'd5;
            else               a = 12'($urandom);
            d = (a == BASE + 12'd2) ? 32'($urandom_range(0, 7)) : 32'($urandom);
            step(op == 1, op == 2, a, d, 1'($urandom_range(0, 1)), 4'($urandom), 0);
        end

        wr(4, 32'hDEAD_BEEF);
        push(4'd9);
        step(1, 0, BASE + 12'd4, 32'h0, 0, 4'h0, 1);
        chk("reset_mid_read_hit", 32'(io_hit), 32'h0);
        chk("reset_mid_read_score", score_out, 32'h0);
        for (int i = 0; i < 5; i++) rd(i);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
